// File: rtl/fft_mux_tree.sv
// Pipelined NUM_INPUTS:1 sample selector for the FFT core, built as a tree of registered RADIX:1 stages.
// Each stage consumes one select digit; the full select and a valid bit travel alongside the data.
module fft_mux_tree #(
    parameter int  DATA_WIDTH = 8,
    parameter int  NUM_INPUTS = 2048,
    parameter int  RADIX      = 16,
    localparam int SEL_WIDTH  = $clog2(NUM_INPUTS),
    localparam int STAGES     = (SEL_WIDTH + $clog2(RADIX) - 1) / $clog2(RADIX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  valid_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic [DATA_WIDTH-1:0] data_i [NUM_INPUTS],
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [SEL_WIDTH-1:0]  sel_o
);
    localparam int D    = $clog2(RADIX);
    localparam int SELX = STAGES * D;

    // Entries feeding stage s; stage_width(STAGES) is always 1 because RADIX**STAGES >= NUM_INPUTS.
    function automatic int stage_width(input int s);
        int n;
        n = NUM_INPUTS;
        for (int i = 0; i < s; i++) begin
            n = (n + RADIX - 1) / RADIX;
        end
        return n;
    endfunction

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int IN_N  = stage_width(s);
        localparam int OUT_N = stage_width(s + 1);

        logic [DATA_WIDTH-1:0] in_s  [IN_N];
        logic                  in_vld_s;
        logic [SEL_WIDTH-1:0]  in_sel_s;
        logic [D-1:0]          dig_s;
        logic [DATA_WIDTH-1:0] nxt_s [OUT_N];
        logic [DATA_WIDTH-1:0] dat_r [OUT_N];
        logic                  vld_r;
        logic [SEL_WIDTH-1:0]  sel_r;

        if (s == 0) begin : g_src
            assign in_s     = data_i;
            assign in_vld_s = valid_i;
            assign in_sel_s = sel_i;
        end else begin : g_src
            assign in_s     = g_stage[s-1].dat_r;
            assign in_vld_s = g_stage[s-1].vld_r;
            assign in_sel_s = g_stage[s-1].sel_r;
        end

        // Zero-extended select, so the top digit reads 0 above SEL_WIDTH.
        assign dig_s = D'(SELX'(in_sel_s) >> (s * D));

        for (genvar g = 0; g < OUT_N; g++) begin : g_grp
            logic [DATA_WIDTH-1:0] pad_s [RADIX];

            // Missing tail elements read as zero; this also yields 0 for out-of-range selects.
            for (genvar e = 0; e < RADIX; e++) begin : g_el
                if (g * RADIX + e < IN_N) begin : g_real
                    assign pad_s[e] = in_s[g * RADIX + e];
                end else begin : g_tail
                    assign pad_s[e] = '0;
                end
            end

            assign nxt_s[g] = in_vld_s ? pad_s[dig_s] : '0;
        end

        // Stage register: reset clears, en=0 holds everything, bubbles carry zero data and select.
        always_ff @(posedge clk) begin
            if (rst) begin
                dat_r <= '{default: '0};
                vld_r <= 1'b0;
                sel_r <= '0;
            end else if (en) begin
                dat_r <= nxt_s;
                vld_r <= in_vld_s;
                sel_r <= in_vld_s ? in_sel_s : '0;
            end
        end
    end

    assign valid_o = g_stage[STAGES-1].vld_r;
    assign data_o  = g_stage[STAGES-1].dat_r[0];
    assign sel_o   = g_stage[STAGES-1].sel_r;

endmodule

// File: tb/tb_fft_mux_tree.sv
// Directed bench for fft_mux_tree: four configurations driven from one vector table
// plus a hand-written check of the single-stage case.
module tb_fft_mux_tree;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default tree: 2048 inputs, radix 16, 16-bit samples, 3 stages.
    logic        en_a, vld_a, vo_a;
    logic [10:0] sel_a, so_a;
    logic [15:0] da [2048];
    logic [15:0] do_a;
    // 100 inputs, radix 4, 4 stages.
    logic        en_b, vld_b, vo_b;
    logic [6:0]  sel_b, so_b;
    logic [7:0]  db [100];
    logic [7:0]  do_b;
    // 8 inputs, radix 2, 3 stages.
    logic        en_c, vld_c, vo_c;
    logic [2:0]  sel_c, so_c;
    logic [7:0]  dc [8];
    logic [7:0]  do_c;
    // 16 inputs, radix 16, single stage.
    logic        en_d, vld_d, vo_d;
    logic [3:0]  sel_d, so_d;
    logic [7:0]  dd [16];
    logic [7:0]  do_d;

    fft_mux_tree #(.DATA_WIDTH(16), .NUM_INPUTS(2048), .RADIX(16)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .valid_i(vld_a), .sel_i(sel_a), .data_i(da),
        .valid_o(vo_a), .data_o(do_a), .sel_o(so_a));
    fft_mux_tree #(.DATA_WIDTH(8), .NUM_INPUTS(100), .RADIX(4)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .valid_i(vld_b), .sel_i(sel_b), .data_i(db),
        .valid_o(vo_b), .data_o(do_b), .sel_o(so_b));
    fft_mux_tree #(.DATA_WIDTH(8), .NUM_INPUTS(8), .RADIX(2)) u_c (
        .clk(clk), .rst(rst), .en(en_c), .valid_i(vld_c), .sel_i(sel_c), .data_i(dc),
        .valid_o(vo_c), .data_o(do_c), .sel_o(so_c));
    fft_mux_tree #(.DATA_WIDTH(8), .NUM_INPUTS(16), .RADIX(16)) u_d (
        .clk(clk), .rst(rst), .en(en_d), .valid_i(vld_d), .sel_i(sel_d), .data_i(dd),
        .valid_o(vo_d), .data_o(do_d), .sel_o(so_d));

    typedef struct {
        int          dut;
        bit          rst;
        bit          en;
        bit          vld;
        logic [10:0] sel;
        bit          ev;
        logic [15:0] ed;
        bit          cs;
        logic [10:0] es;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int dut, input bit r, input bit e, input bit v, input logic [10:0] s,
                       input bit ev, input logic [15:0] ed, input bit cs, input logic [10:0] es);
        vec_t t;
        t.dut = dut; t.rst = r; t.en = e; t.vld = v; t.sel = s;
        t.ev = ev; t.ed = ed; t.cs = cs; t.es = es;
        tbl.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst;
        case (t.dut)
            0: begin en_a = t.en; vld_a = t.vld; sel_a = t.sel; end
            1: begin en_b = t.en; vld_b = t.vld; sel_b = t.sel[6:0]; end
            2: begin en_c = t.en; vld_c = t.vld; sel_c = t.sel[2:0]; end
            default: begin en_d = t.en; vld_d = t.vld; sel_d = t.sel[3:0]; end
        endcase
    endtask

    task automatic observe(input int dut, output logic ov, output logic [15:0] od,
                           output logic [10:0] os);
        case (dut)
            0: begin ov = vo_a; od = do_a; os = so_a; end
            1: begin ov = vo_b; od = {8'h00, do_b}; os = {4'h0, so_b}; end
            2: begin ov = vo_c; od = {8'h00, do_c}; os = {8'h00, so_c}; end
            default: begin ov = vo_d; od = {8'h00, do_d}; os = {7'h00, so_d}; end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        logic        ov;
        logic [15:0] od;
        logic [10:0] os;
        int          seen;
        int          first;

        rst = 1'b1;
        en_a = 1'b1; vld_a = 1'b0; sel_a = 11'h000;
        en_b = 1'b1; vld_b = 1'b0; sel_b = 7'h00;
        en_c = 1'b1; vld_c = 1'b0; sel_c = 3'h0;
        en_d = 1'b1; vld_d = 1'b0; sel_d = 4'h0;
        for (int k = 0; k < 2048; k++) da[k] = 16'(k);
        for (int k = 0; k < 100; k++) db[k] = 8'(k + 1);
        for (int k = 0; k < 8; k++) dc[k] = 8'(8'hA0 + k);
        for (int k = 0; k < 16; k++) dd[k] = 8'(k);
        dd[15] = 8'h3C;

        // Reset state.
        add(0, 1'b1, 1'b1, 1'b0, 11'h000, 1'b0, 16'h0000, 1'b1, 11'h000);
        add(0, 1'b1, 1'b1, 1'b0, 11'h000, 1'b0, 16'h0000, 1'b1, 11'h000);
        // Back-to-back stream, latency 3.
        add(0, 1'b0, 1'b1, 1'b1, 11'h000, 1'b0, 16'h0000, 1'b0, 11'h000);
        add(0, 1'b0, 1'b1, 1'b1, 11'h5A3, 1'b0, 16'h0000, 1'b0, 11'h000);
        add(0, 1'b0, 1'b1, 1'b1, 11'h7FF, 1'b1, 16'h0000, 1'b1, 11'h000);
        add(0, 1'b0, 1'b1, 1'b1, 11'h010, 1'b1, 16'h05A3, 1'b1, 11'h5A3);
        add(0, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 16'h07FF, 1'b1, 11'h7FF);
        add(0, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 16'h0010, 1'b1, 11'h010);
        add(0, 1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 16'h0000, 1'b0, 11'h000);
        // Stall: 0x123 sits in stage 0 while en=0; valid_i during stall is ignored.
        add(0, 1'b0, 1'b1, 1'b1, 11'h0AA, 1'b0, 16'h0000, 1'b0, 11'h000);
        add(0, 1'b0, 1'b1, 1'b1, 11'h0BB, 1'b0, 16'h0000, 1'b0, 11'h000);
        add(0, 1'b0, 1'b1, 1'b1, 11'h123, 1'b1, 16'h00AA, 1'b1, 11'h0AA);
        for (int k = 0; k < 5; k++)
            add(0, 1'b0, 1'b0, 1'b1, 11'h555, 1'b1, 16'h00AA, 1'b1, 11'h0AA);
        add(0, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 16'h00BB, 1'b1, 11'h0BB);
        add(0, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 16'h0123, 1'b1, 11'h123);
        add(0, 1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 16'h0000, 1'b0, 11'h000);
        add(0, 1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 16'h0000, 1'b0, 11'h000);
        // Reset with a full pipeline: nothing from before the reset may emerge.
        add(0, 1'b0, 1'b1, 1'b1, 11'h111, 1'b0, 16'h0000, 1'b0, 11'h000);
        add(0, 1'b0, 1'b1, 1'b1, 11'h222, 1'b0, 16'h0000, 1'b0, 11'h000);
        add(0, 1'b0, 1'b1, 1'b1, 11'h333, 1'b1, 16'h0111, 1'b1, 11'h111);
        add(0, 1'b1, 1'b1, 1'b1, 11'h444, 1'b0, 16'h0000, 1'b1, 11'h000);
        add(0, 1'b0, 1'b1, 1'b1, 11'h400, 1'b0, 16'h0000, 1'b1, 11'h000);
        add(0, 1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 16'h0000, 1'b0, 11'h000);
        add(0, 1'b0, 1'b1, 1'b0, 11'h000, 1'b1, 16'h0400, 1'b1, 11'h400);
        add(0, 1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 16'h0000, 1'b0, 11'h000);
        // Non-power-of-two input count, out-of-range selects, latency 4.
        add(1, 1'b0, 1'b1, 1'b1, 11'd99,  1'b0, 16'h0000, 1'b0, 11'h000);
        add(1, 1'b0, 1'b1, 1'b1, 11'd100, 1'b0, 16'h0000, 1'b0, 11'h000);
        add(1, 1'b0, 1'b1, 1'b1, 11'd127, 1'b0, 16'h0000, 1'b0, 11'h000);
        add(1, 1'b0, 1'b1, 1'b0, 11'd0,   1'b1, 16'd100,   1'b1, 11'd99);
        add(1, 1'b0, 1'b1, 1'b0, 11'd0,   1'b1, 16'd0,     1'b1, 11'd100);
        add(1, 1'b0, 1'b1, 1'b0, 11'd0,   1'b1, 16'd0,     1'b1, 11'd127);
        add(1, 1'b0, 1'b1, 1'b0, 11'd0,   1'b0, 16'd0,     1'b0, 11'd0);
        // Radix 2 with alternating bubbles; bubble data must read 0.
        add(2, 1'b0, 1'b1, 1'b1, 11'd5, 1'b0, 16'h0000, 1'b0, 11'd0);
        add(2, 1'b0, 1'b1, 1'b0, 11'd7, 1'b0, 16'h0000, 1'b0, 11'd0);
        add(2, 1'b0, 1'b1, 1'b1, 11'd2, 1'b1, 16'h00A5, 1'b1, 11'd5);
        add(2, 1'b0, 1'b1, 1'b0, 11'd7, 1'b0, 16'h0000, 1'b0, 11'd0);
        add(2, 1'b0, 1'b1, 1'b0, 11'd7, 1'b1, 16'h00A2, 1'b1, 11'd2);
        add(2, 1'b0, 1'b1, 1'b0, 11'd0, 1'b0, 16'h0000, 1'b0, 11'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            tick();
            observe(tbl[i].dut, ov, od, os);
            check($sformatf("row%0d valid_o", i), {31'd0, ov}, {31'd0, tbl[i].ev});
            check($sformatf("row%0d data_o", i), {16'd0, od}, {16'd0, tbl[i].ed});
            if (tbl[i].cs)
                check($sformatf("row%0d sel_o", i), {21'd0, os}, {21'd0, tbl[i].es});
        end

        // Single-stage tree: one edge of latency, valid for exactly one cycle.
        sel_d = 4'hF; vld_d = 1'b1;
        tick();
        vld_d = 1'b0;
        check("single data_o", {24'd0, do_d}, 32'h0000_003C);
        check("single valid_o", {31'd0, vo_d}, 32'd1);
        check("single sel_o", {28'd0, so_d}, 32'h0000_000F);
        tick();
        check("single bubble valid_o", {31'd0, vo_d}, 32'd0);
        check("single bubble data_o", {24'd0, do_d}, 32'd0);

        sel_d = 4'h3; vld_d = 1'b1;
        seen = 0;
        first = -1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            vld_d = 1'b0;
            if (vo_d) begin
                seen++;
                if (first < 0) first = c;
                check("single sel3 data_o", {24'd0, do_d}, 32'd3);
            end
        end
        check("single sel3 latency", first, 32'd1);
        check("single sel3 valid count", seen, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fft_mux_tree.md
Name: fft_mux_tree

Overview:
Parametrised, pipelined NUM_INPUTS:1 selector for the FFT core, built as a tree of RADIX:1 registered stages. It picks one sample out of a wide FFT buffer, for example in output reordering or bin extraction. It generalises the fixed 16:1 single-register mux with configurable width, depth and radix, a valid pipeline, a stall enable, synchronous reset, a select echo, and defined out-of-range handling. The default configuration (2048 inputs, radix 16) gives the 3-stage latency the 2048-point core expects.

Parameters:
DATA_WIDTH, 8, bits per sample
NUM_INPUTS, 2048, number of selectable inputs; any value ≥2, need not be a power of two
RADIX, 16, fan-in per stage; power of two, ≥2
SEL_WIDTH, $clog2(NUM_INPUTS), select width (derived, not overridden)
STAGES, ceil(SEL_WIDTH / log2(RADIX)), pipeline depth (derived)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
en  in  1  pipeline advance; 0 = every register holds
valid_i  in  1  sel_i/data_i qualified this cycle
sel_i  in  SEL_WIDTH  index of input to forward
data_i  in  DATA_WIDTH x NUM_INPUTS  unpacked input array, sampled only when en=1 and valid_i=1
valid_o  out  1  data_o/sel_o qualified
data_o  out  DATA_WIDTH  selected sample
sel_o  out  SEL_WIDTH  sel_i that produced data_o

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a clk edge with rst=1, all stage data, valid and sel registers clear to 0, so valid_o=0, data_o=0 and sel_o=0 from the next cycle. rst takes priority over en. In-flight samples are discarded, not flushed.
- Digit split: D = log2(RADIX). Stage s (0..STAGES-1) uses sel bits [s*D +: D]. The top digit is zero-extended where SEL_WIDTH is not a multiple of D.
- Stage 0: groups data_i into ceil(NUM_INPUTS/RADIX) chunks of RADIX. Each group registers the element chosen by digit 0. Missing tail elements are treated as 0.
- Stage s>0: performs the same reduction on the registered outputs of stage s-1, using digit s.
- The remaining sel bits, the full sel, and valid travel alongside the data in each stage register.
- Final stage has exactly one group; its register drives data_o and sel_o.
- Out of range: if sel_i ≥ NUM_INPUTS, data_o=0 when that entry emerges. valid_o still asserts and sel_o echoes the raw sel_i.
- Latency: with en held 1, a sample accepted at edge N appears on valid_o/data_o after edge N+STAGES-1, i.e. STAGES register stages.
- Throughput: one sample per cycle, back-to-back, no bubbles required.
- en=0: every stage register holds, including valid, and valid_o stays as it was. Resuming en=1 continues with no loss or duplication. valid_i is ignored while en=0.
- valid_i=0 with en=1: a bubble (valid=0) propagates. Data registers may load don't-care values, but data_o must read 0 whenever valid_o=0.
- No combinational path from any input to any output.
- NUM_INPUTS ≤ RADIX degenerates to STAGES=1, a single registered mux.

Test Plan:
- Default config, DATA_WIDTH=16, data_i[k]=k. Stream valid sel_i = 0x000, 0x5A3, 0x7FF, 0x010 on consecutive cycles with en=1 → valid_o high for 4 consecutive cycles starting 3 cycles later, data_o = 0x0000, 0x05A3, 0x07FF, 0x0010, and sel_o matching.
- Same setup, issue sel_i=0x123 then drop en for 5 cycles after 1 edge → outputs frozen during the stall. data_o=0x0123 with valid_o=1 appears exactly 2 enabled edges after resume, never duplicated.
- Fill the pipeline with 3 valid entries, assert rst for 1 cycle → next cycle valid_o=0, data_o=0, sel_o=0. No pre-reset entry ever emerges. A new sel_i=0x400 after reset returns 0x0400 at latency 3.
- NUM_INPUTS=100, RADIX=4 (SEL_WIDTH=7, STAGES=4), data_i[k]=k+1. Issue sel_i=99, then 100, then 127 → data_o=100, then 0, then 0, all with valid_o=1 and sel_o echoed, latency 4.
- RADIX=2, NUM_INPUTS=8. Alternate valid_i 1/0 with sel_i=5 then 2, data_i[k]=0xA0+k → latency 3, outputs 0xA5, bubble, 0xA2. data_o=0 on the bubble cycles.
- NUM_INPUTS=16, RADIX=16 → STAGES=1. sel_i=0xF, data_i[15]=0x3C → data_o=0x3C one edge later, valid_o high for exactly one cycle.
